// File: rtl/mem_bus_initiator.sv
// rtl/mem_bus_initiator.sv - cache-line master for the C2 line bus (READ/WRITE, timeout, turnaround)
module mem_bus_initiator #(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic                                       req_write,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] req_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0]               req_wdata,
    output logic                                       resp_valid,
    output logic [CACHE_LINE_SIZE*8-1:0]               resp_rdata,
    output logic                                       resp_timeout,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                        data,
    inout  wire  [1:0]                                 command
);
    localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
    localparam int BEATS     = LINE_BITS / BUS_SIZE;
    localparam int BEAT_W    = $clog2(BEATS + 1);
    localparam int BIDX_W    = $clog2(BEATS);
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CMD_RESPONSE = 2'b01;
    localparam logic [1:0] CMD_READ     = 2'b10;
    localparam logic [1:0] CMD_WRITE    = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        XFER  = 3'd3,
        TURN  = 3'd4
    } state_t;

    state_t                state, next_state;
    logic                  wr_q;
    logic [LINE_BITS-1:0]  wdata_q;
    logic [LINE_BITS-1:0]  rd_buf, rd_next;
    logic [TO_W-1:0]       wait_cnt;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [BIDX_W-1:0]     beat_idx;
    logic                  turn_cnt;
    logic                  cmd_oe, data_oe;
    logic                  done_ok, done_to;
    logic                  rsp_seen;
    logic [BUS_SIZE-1:0]   data_out;

    // X or Z on the bus never compares equal, so a floating bus is not a response
    assign rsp_seen = (command == CMD_RESPONSE);
    assign beat_idx = beat_cnt[BIDX_W-1:0];
    assign data_out = wdata_q[BUS_SIZE*beat_idx +: BUS_SIZE];

    assign command = cmd_oe  ? (wr_q ? CMD_WRITE : CMD_READ) : 2'bzz;
    assign data    = data_oe ? data_out : {BUS_SIZE{1'bz}};

    always_comb begin
        rd_next = rd_buf;
        rd_next[BUS_SIZE*beat_idx +: BUS_SIZE] = data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        cmd_oe     = 1'b0;
        data_oe    = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = ISSUE;
            end
            ISSUE: begin
                cmd_oe     = 1'b1;
                data_oe    = wr_q;
                next_state = WAIT;
            end
            WAIT: begin
                // a response in the last allowed cycle still wins over the timeout
                data_oe = wr_q;
                if (rsp_seen) begin
                    next_state = XFER;
                end else if (wait_cnt == TO_LAST) begin
                    next_state = TURN;
                    done_to    = 1'b1;
                end
            end
            XFER: begin
                data_oe = wr_q;
                if (beat_cnt == LAST_BEAT) begin
                    next_state = TURN;
                    done_ok    = 1'b1;
                end
            end
            TURN: begin
                if (turn_cnt) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            address      <= '0;
            rd_buf       <= '0;
            resp_rdata   <= '0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            wait_cnt     <= '0;
            beat_cnt     <= '0;
            turn_cnt     <= 1'b0;
        end else begin
            resp_valid   <= done_ok || done_to;
            resp_timeout <= done_to;
            case (state)
                IDLE: begin
                    turn_cnt <= 1'b0;
                    if (req_valid) begin
                        wr_q     <= req_write;
                        wdata_q  <= req_wdata;
                        address  <= req_addr;
                        wait_cnt <= '0;
                        beat_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (rsp_seen) begin
                        if (!wr_q) rd_buf <= rd_next;
                        beat_cnt <= BEAT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                XFER: begin
                    if (!wr_q) rd_buf <= rd_next;
                    if (beat_cnt == LAST_BEAT) begin
                        if (!wr_q) resp_rdata <= rd_next;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                TURN: turn_cnt <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb/tb_mem_bus_initiator.sv - vector table plus reset/back-to-back sequences for mem_bus_initiator
module tb_mem_bus_initiator;
    localparam int TO = 255;
    localparam logic [127:0] LINE0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    localparam logic [127:0] W1    = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    localparam logic [127:0] W2    = 128'h1234_5678_9ABC_DEF0_0F0F_F0F0_5A5A_A5A5;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, req_write;
    logic [14:0]  req_addr, address;
    logic [127:0] req_wdata, resp_rdata;
    logic         resp_valid, resp_timeout;
    tri0  [15:0]  data;
    tri0  [1:0]   command;

    logic         mem_cmd_oe = 1'b0;
    logic         mem_data_oe = 1'b0;
    logic [15:0]  mem_data = 16'h0;
    logic [127:0] mem [0:31];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign command = mem_cmd_oe  ? 2'b01 : 2'bzz;
    assign data    = mem_data_oe ? mem_data : 16'hzzzz;

    mem_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
        .address(address), .data(data), .command(command)
    );

    typedef struct {
        logic         wr;
        logic [14:0]  addr;
        logic [127:0] wdata;
        int           lat;
        logic         respond;
        logic         hold;
        logic         exp_to;
        logic [127:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input string what, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, what, act, exp);
        end
    endtask

    task automatic run_txn(input logic wr, input logic [14:0] a, input logic [127:0] wd, input int lat,
                           input logic respond, input logic hold, input logic exp_to,
                           input logic [127:0] exp_rd, input int rst_beat, input string nm);
        int n;
        int bad;
        logic [127:0] line;
        logic [127:0] wbeats;
        line   = mem[a[4:0]];
        wbeats = '0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(nm, "accept_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = hold; req_write = ~wr; req_addr = ~a; req_wdata = ~wd;
        @(negedge clk);
        check(nm, "issue", {req_ready, resp_valid, command, address, data},
              {1'b0, 1'b0, 1'b1, wr, a, (wr ? wd[15:0] : 16'h0)});
        if (wr) wbeats[15:0] = data;
        if (respond) begin
            bad = 0;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                if (command !== 2'b00 || data !== (wr ? wd[15:0] : 16'h0) ||
                    resp_valid !== 1'b0 || address !== a) bad++;
            end
            check(nm, "wait_bus_bad_cycles", bad, 0);
            mem_cmd_oe = 1'b1;
            if (!wr) begin
                mem_data_oe = 1'b1;
                mem_data    = line[15:0];
            end
            bad = 0;
            for (int b = 1; b < 8; b++) begin
                @(negedge clk);
                if (b >= 2 && command !== 2'b00) bad++;
                if (resp_valid !== 1'b0 || address !== a) bad++;
                mem_cmd_oe = 1'b0;
                if (wr) wbeats[b*16 +: 16] = data;
                else    mem_data = line[b*16 +: 16];
                if (b == rst_beat) begin
                    reset = 1'b0;
                    mem_data_oe = 1'b0;
                    #1;
                    check(nm, "reset_outputs", {req_ready, resp_valid, resp_timeout, address, command, data},
                          {1'b1, 1'b0, 1'b0, 15'h0, 2'b00, 16'h0});
                    check(nm, "reset_rdata", resp_rdata, 128'h0);
                    @(negedge clk);
                    reset = 1'b1;
                    n = 0;
                    repeat (10) begin
                        @(negedge clk);
                        if (resp_valid !== 1'b0 || req_ready !== 1'b1) n++;
                    end
                    check(nm, "post_reset_idle_bad", n, 0);
                    return;
                end
            end
            check(nm, "xfer_bad_cycles", bad, 0);
            @(negedge clk);
            mem_data_oe = 1'b0;
            #1;
        end else begin
            n = 0;
            bad = 0;
            while (resp_valid !== 1'b1 && n < TO + 8) begin
                @(negedge clk);
                n++;
                if (command !== 2'b00 || data !== ((wr && !resp_valid) ? wd[15:0] : 16'h0)) bad++;
            end
            check(nm, "timeout_latency", n, TO + 1);
            check(nm, "timeout_wait_bus_bad", bad, 0);
        end
        check(nm, "turn1", {resp_valid, resp_timeout, req_ready, command, data},
              {1'b1, exp_to, 1'b0, 2'b00, 16'h0});
        check(nm, "rdata", resp_rdata, exp_rd);
        if (wr && respond) begin
            mem[a[4:0]] = wbeats;
            check(nm, "mem_line", wbeats, wd);
        end
        @(negedge clk);
        check(nm, "turn2", {resp_valid, req_ready, command, data}, {1'b0, 1'b0, 2'b00, 16'h0});
        @(negedge clk);
        check(nm, "idle", {resp_valid, req_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //          wr    addr      wdata  lat  rsp   hold  to    exp_rd
        vecs[0] = '{1'b0, 15'h0005, '0,    100, 1'b1, 1'b0, 1'b0, LINE0};
        vecs[1] = '{1'b1, 15'h0010, W1,    3,   1'b1, 1'b0, 1'b0, LINE0};
        vecs[2] = '{1'b0, 15'h0010, '0,    1,   1'b1, 1'b0, 1'b0, W1};
        vecs[3] = '{1'b0, 15'h0007, '0,    0,   1'b0, 1'b0, 1'b1, W1};
        vecs[4] = '{1'b1, 15'h0007, W2,    TO,  1'b1, 1'b0, 1'b0, W1};
        vecs[5] = '{1'b0, 15'h0007, '0,    TO,  1'b1, 1'b0, 1'b0, W2};
        vecs[6] = '{1'b1, 15'h7FFF, W1,    2,   1'b1, 1'b1, 1'b0, W2};
        vecs[7] = '{1'b0, 15'h7FFF, '0,    2,   1'b1, 1'b1, 1'b0, W1};
        vecs[8] = '{1'b1, 15'h0005, W2,    4,   1'b1, 1'b1, 1'b0, W1};
        vecs[9] = '{1'b0, 15'h0005, '0,    4,   1'b1, 1'b0, 1'b0, W2};
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[5] = LINE0;

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset", "outputs", {req_ready, resp_valid, resp_timeout, address, command, data},
              {1'b1, 1'b0, 1'b0, 15'h0, 2'b00, 16'h0});
        check("reset", "rdata", resp_rdata, 128'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].respond,
                    vecs[i].hold, vecs[i].exp_to, vecs[i].exp_rd, -1, $sformatf("vec%0d", i));
        end

        run_txn(1'b0, 15'h0005, '0, 4, 1'b1, 1'b0, 1'b0, '0, 3, "abort_read");
        run_txn(1'b0, 15'h0005, '0, 6, 1'b1, 1'b0, 1'b0, W2, -1, "read_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
